// File: rtl/mem_port_arbiter_if.sv
// Request/response and memory-side bundle for mem_port_arbiter.
// The arbiter uses the slave view; requesters and the memory model use the master view.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  dbg_req;
   logic                  dbg_we;
   logic [ADDR_W-1:0]     dbg_addr;
   logic [DATA_W-1:0]     dbg_wdata;
   logic [DATA_W/8-1:0]   dbg_be;
   logic                  dbg_gnt;
   logic                  dbg_rvalid;

   logic                  ls_req;
   logic                  ls_we;
   logic [ADDR_W-1:0]     ls_addr;
   logic [DATA_W-1:0]     ls_wdata;
   logic [DATA_W/8-1:0]   ls_be;
   logic                  ls_gnt;
   logic                  ls_rvalid;

   logic                  if_req;
   logic [ADDR_W-1:0]     if_addr;
   logic                  if_gnt;
   logic                  if_rvalid;

   logic [DATA_W-1:0]     rdata;
   logic                  mem_en;
   logic                  mem_we;
   logic [ADDR_W-1:0]     mem_addr;
   logic [DATA_W-1:0]     mem_wdata;
   logic [DATA_W/8-1:0]   mem_be;
   logic [DATA_W-1:0]     mem_rdata;
   logic                  busy;

   modport slave (
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_be,
      output dbg_gnt, dbg_rvalid,
      input  ls_req, ls_we, ls_addr, ls_wdata, ls_be,
      output ls_gnt, ls_rvalid,
      input  if_req, if_addr,
      output if_gnt, if_rvalid,
      output rdata, mem_en, mem_we, mem_addr, mem_wdata, mem_be, busy,
      input  mem_rdata
   );

   modport master (
      output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_be,
      input  dbg_gnt, dbg_rvalid,
      output ls_req, ls_we, ls_addr, ls_wdata, ls_be,
      input  ls_gnt, ls_rvalid,
      output if_req, if_addr,
      input  if_gnt, if_rvalid,
      input  rdata, mem_en, mem_we, mem_addr, mem_wdata, mem_be, busy,
      output mem_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Three-way arbiter (debug, load/store, fetch) in front of one single-port memory.
// One transaction in flight; fetch is promoted above load/store after STARVE_MAX lost arbitrations.
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   mem_port_arbiter_if.slave bus
);
   localparam logic [3:0] LAT    = 4'(MEM_LAT);
   localparam logic [3:0] STARVE = 4'(STARVE_MAX);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_DBG, OWN_LS, OWN_IF} owner_t;

   state_t     state;
   owner_t     owner;
   owner_t     winner;
   logic [3:0] lat_cnt;
   logic [3:0] starve_cnt;
   logic [2:0] gnt_q;     // {dbg, ls, if}
   logic [2:0] rvalid_q;  // {dbg, ls, if}

   function automatic logic [2:0] sel(input owner_t o);
      case (o)
         OWN_DBG: return 3'b100;
         OWN_LS:  return 3'b010;
         OWN_IF:  return 3'b001;
         default: return 3'b000;
      endcase
   endfunction

   // NOTE: winner gets a default before the priority chain so no latch is inferred.
   always_comb begin
      winner = OWN_NONE;
      if (bus.dbg_req)                              winner = OWN_DBG;
      else if (bus.if_req && starve_cnt == STARVE)  winner = OWN_IF;
      else if (bus.ls_req)                          winner = OWN_LS;
      else if (bus.if_req)                          winner = OWN_IF;
   end

   // NOTE: all state and registered outputs use non-blocking assignments so every
   // read in this block sees the pre-edge value.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= IDLE;
         owner         <= OWN_NONE;
         lat_cnt       <= '0;
         starve_cnt    <= '0;
         gnt_q         <= '0;
         rvalid_q      <= '0;
         bus.busy      <= 1'b0;
         bus.mem_en    <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.mem_be    <= '0;
      end else begin
         gnt_q      <= '0;
         bus.mem_en <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.if_req && winner != OWN_IF) begin
                  if (starve_cnt < STARVE) starve_cnt <= starve_cnt + 4'd1;
               end else begin
                  starve_cnt <= '0;
               end
               if (winner != OWN_NONE) begin
                  state      <= ISSUE;
                  owner      <= winner;
                  bus.busy   <= 1'b1;
                  bus.mem_en <= 1'b1;
                  gnt_q      <= sel(winner);
                  case (winner)
                     OWN_DBG: begin
                        bus.mem_we    <= bus.dbg_we;
                        bus.mem_addr  <= bus.dbg_addr;
                        bus.mem_wdata <= bus.dbg_wdata;
                        bus.mem_be    <= bus.dbg_be;
                     end
                     OWN_LS: begin
                        bus.mem_we    <= bus.ls_we;
                        bus.mem_addr  <= bus.ls_addr;
                        bus.mem_wdata <= bus.ls_wdata;
                        bus.mem_be    <= bus.ls_be;
                     end
                     default: begin
                        bus.mem_we    <= 1'b0;
                        bus.mem_addr  <= bus.if_addr;
                        bus.mem_wdata <= '0;
                        bus.mem_be    <= '1;
                     end
                  endcase
               end
            end
            ISSUE: begin
               state   <= WAIT;
               lat_cnt <= 4'd1;
               if (LAT == 4'd1) rvalid_q <= sel(owner);
            end
            WAIT: begin
               // rvalid is set one cycle early so it is high exactly while lat_cnt == LAT.
               if (lat_cnt == LAT) begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
                  rvalid_q <= '0;
                  lat_cnt  <= '0;
               end else begin
                  lat_cnt <= lat_cnt + 4'd1;
                  if (lat_cnt + 4'd1 == LAT) rvalid_q <= sel(owner);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.dbg_gnt    = gnt_q[2];
   assign bus.ls_gnt     = gnt_q[1];
   assign bus.if_gnt     = gnt_q[0];
   assign bus.dbg_rvalid = rvalid_q[2];
   assign bus.ls_rvalid  = rvalid_q[1];
   assign bus.if_rvalid  = rvalid_q[0];

   // Memory data is only valid in the response cycle, so rdata cannot be registered earlier.
   assign bus.rdata = (rvalid_q != 3'b000 && !bus.mem_we) ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MEM_LAT=1, one with MEM_LAT=3,
// each backed by a small memory model, responses checked against a scoreboard queue.
module tb_mem_port_arbiter;
   localparam int W_IF  = 0;
   localparam int W_LS  = 1;
   localparam int W_DBG = 2;

   typedef struct {
      int          who;
      logic [31:0] data;
   } exp_t;

   logic clk;
   logic rst1;
   logic rst3;
   int   total;
   int   bad;
   exp_t q1[$];
   exp_t q3[$];
   exp_t e1;
   exp_t e3;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut1 (
      .clk(clk), .rst(rst1), .bus(b1)
   );
   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) dut3 (
      .clk(clk), .rst(rst3), .bus(b3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory models: word-indexed arrays, byte-enable writes, MEM_LAT-deep read pipeline.
   logic [31:0] mem1 [256];
   logic [31:0] mem3 [256];
   logic [31:0] pipe1;
   logic [31:0] pipe3 [3];

   always @(posedge clk) begin
      if (b1.mem_en && b1.mem_we)
         for (int i = 0; i < 4; i++)
            if (b1.mem_be[i]) mem1[b1.mem_addr[9:2]][8*i +: 8] <= b1.mem_wdata[8*i +: 8];
      pipe1 <= b1.mem_en ? mem1[b1.mem_addr[9:2]] : 32'h0;
   end
   assign b1.mem_rdata = pipe1;

   always @(posedge clk) begin
      if (b3.mem_en && b3.mem_we)
         for (int i = 0; i < 4; i++)
            if (b3.mem_be[i]) mem3[b3.mem_addr[9:2]][8*i +: 8] <= b3.mem_wdata[8*i +: 8];
      pipe3[0] <= b3.mem_en ? mem3[b3.mem_addr[9:2]] : 32'h0;
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
   end
   assign b3.mem_rdata = pipe3[2];

   logic [2:0] gnt1, rv1, gnt3, rv3;
   assign gnt1 = {b1.dbg_gnt, b1.ls_gnt, b1.if_gnt};
   assign rv1  = {b1.dbg_rvalid, b1.ls_rvalid, b1.if_rvalid};
   assign gnt3 = {b3.dbg_gnt, b3.ls_gnt, b3.if_gnt};
   assign rv3  = {b3.dbg_rvalid, b3.ls_rvalid, b3.if_rvalid};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] onehot(input int who);
      return 32'(1) << who;
   endfunction

   // Scoreboard monitors: every response pulse pops one expected entry.
   always @(negedge clk) begin
      if (rv1 != 3'b000) begin
         if (q1.size() == 0) check("sb1_unexpected_rvalid", 32'(rv1), 32'h0);
         else begin
            e1 = q1.pop_front();
            check("sb1_who", 32'(rv1), onehot(e1.who));
            check("sb1_rdata", b1.rdata, e1.data);
         end
      end
   end

   always @(negedge clk) begin
      if (rv3 != 3'b000) begin
         if (q3.size() == 0) check("sb3_unexpected_rvalid", 32'(rv3), 32'h0);
         else begin
            e3 = q3.pop_front();
            check("sb3_who", 32'(rv3), onehot(e3.who));
            check("sb3_rdata", b3.rdata, e3.data);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   logic [31:0] eg;
   logic [31:0] er;

   initial begin
      total = 0;
      bad   = 0;
      for (int i = 0; i < 256; i++) begin
         mem1[i] = 32'h0;
         mem3[i] = 32'h0;
      end
      mem1[8'h04] = 32'h00500093;
      mem1[8'h08] = 32'h11111111;
      mem1[8'h09] = 32'h22222222;
      mem1[8'h0A] = 32'h33333333;
      mem1[8'h0C] = 32'h44444444;
      mem1[8'h0D] = 32'h55555555;
      mem1[8'h10] = 32'h12345678;
      mem3[8'h14] = 32'hA5A5A5A5;
      mem3[8'h15] = 32'h5A5A5A5A;
      mem3[8'h16] = 32'h0BADF00D;

      {b1.dbg_req, b1.dbg_we, b1.ls_req, b1.ls_we, b1.if_req} = '0;
      {b1.dbg_addr, b1.dbg_wdata, b1.ls_addr, b1.ls_wdata, b1.if_addr} = '0;
      b1.dbg_be = 4'hF;
      b1.ls_be  = 4'hF;
      {b3.dbg_req, b3.dbg_we, b3.ls_req, b3.ls_we, b3.if_req} = '0;
      {b3.dbg_addr, b3.dbg_wdata, b3.ls_addr, b3.ls_wdata, b3.if_addr} = '0;
      b3.dbg_be = 4'hF;
      b3.ls_be  = 4'hF;
      rst1 = 1'b0;
      rst3 = 1'b0;
      repeat (2) step();

      // Reset state
      check("rst_busy", 32'(b1.busy), 0);
      check("rst_mem_en", 32'(b1.mem_en), 0);
      check("rst_gnt", 32'(gnt1), 0);
      check("rst_rvalid", 32'(rv1), 0);
      check("rst_rdata", b1.rdata, 0);
      check("rst_mem_addr", b1.mem_addr, 0);
      check("rst3_busy", 32'(b3.busy), 0);
      rst1 = 1'b1;
      rst3 = 1'b1;
      step();

      // Single fetch, MEM_LAT=1
      b1.if_req  = 1'b1;
      b1.if_addr = 32'h10;
      q1.push_back('{W_IF, 32'h00500093});
      step();
      check("fetch_gnt", 32'(gnt1), 32'b001);
      check("fetch_mem_en", 32'(b1.mem_en), 1);
      check("fetch_mem_addr", b1.mem_addr, 32'h10);
      check("fetch_mem_we", 32'(b1.mem_we), 0);
      check("fetch_mem_be", 32'(b1.mem_be), 32'hF);
      check("fetch_busy1", 32'(b1.busy), 1);
      b1.if_req = 1'b0;
      step();
      check("fetch_rvalid", 32'(rv1), 32'b001);
      check("fetch_busy2", 32'(b1.busy), 1);
      check("fetch_mem_en_off", 32'(b1.mem_en), 0);
      step();
      check("fetch_idle_busy", 32'(b1.busy), 0);
      check("fetch_idle_rdata", b1.rdata, 0);

      // Priority dbg > ls > if with all three raised together
      b1.dbg_req = 1'b1; b1.dbg_addr = 32'h20;
      b1.ls_req  = 1'b1; b1.ls_addr  = 32'h24;
      b1.if_req  = 1'b1; b1.if_addr  = 32'h28;
      q1.push_back('{W_DBG, 32'h11111111});
      q1.push_back('{W_LS,  32'h22222222});
      q1.push_back('{W_IF,  32'h33333333});
      for (int c = 1; c <= 10; c++) begin
         step();
         eg = (c == 1) ? 32'b100 : (c == 4) ? 32'b010 : (c == 7) ? 32'b001 : 32'b000;
         check("prio_gnt", 32'(gnt1), eg);
         if (gnt1[2]) begin check("prio_addr_dbg", b1.mem_addr, 32'h20); b1.dbg_req = 1'b0; end
         if (gnt1[1]) begin check("prio_addr_ls",  b1.mem_addr, 32'h24); b1.ls_req  = 1'b0; end
         if (gnt1[0]) begin check("prio_addr_if",  b1.mem_addr, 32'h28); b1.if_req  = 1'b0; end
      end

      // Starvation guard: ls held continuously, if promoted on its 5th arbitration
      b1.ls_req = 1'b1; b1.ls_addr = 32'h30;
      b1.if_req = 1'b1; b1.if_addr = 32'h34;
      repeat (4) q1.push_back('{W_LS, 32'h44444444});
      q1.push_back('{W_IF, 32'h55555555});
      q1.push_back('{W_LS, 32'h44444444});
      for (int c = 1; c <= 18; c++) begin
         step();
         eg = (c == 1 || c == 4 || c == 7 || c == 10 || c == 16) ? 32'b010 :
              (c == 13) ? 32'b001 : 32'b000;
         check("starve_gnt", 32'(gnt1), eg);
         if (c == 13) begin
            check("starve_cnt_cleared", 32'(dut1.starve_cnt), 0);
            b1.if_req = 1'b0;
         end
         if (c == 16) b1.ls_req = 1'b0;
      end

      // Write ack with partial byte enables, then read back through dbg
      b1.ls_req = 1'b1; b1.ls_we = 1'b1; b1.ls_addr = 32'h40;
      b1.ls_wdata = 32'hDEADBEEF; b1.ls_be = 4'b0011;
      q1.push_back('{W_LS, 32'h0});
      step();
      check("wr_gnt", 32'(gnt1), 32'b010);
      check("wr_mem_we", 32'(b1.mem_we), 1);
      check("wr_mem_be", 32'(b1.mem_be), 32'h3);
      check("wr_mem_addr", b1.mem_addr, 32'h40);
      check("wr_mem_wdata", b1.mem_wdata, 32'hDEADBEEF);
      b1.ls_req = 1'b0; b1.ls_we = 1'b0; b1.ls_be = 4'hF;
      step();
      check("wr_rvalid", 32'(rv1), 32'b010);
      check("wr_hold_mem_we", 32'(b1.mem_we), 1);
      check("wr_hold_mem_addr", b1.mem_addr, 32'h40);
      step();
      b1.dbg_req = 1'b1; b1.dbg_addr = 32'h40;
      q1.push_back('{W_DBG, 32'h1234BEEF});
      step();
      check("rb_gnt", 32'(gnt1), 32'b100);
      b1.dbg_req = 1'b0;
      step();
      check("rb_rvalid", 32'(rv1), 32'b100);
      step();

      // MEM_LAT=3: rvalid 3 cycles after gnt, next grant 5 cycles after first
      b3.dbg_req = 1'b1; b3.dbg_addr = 32'h50;
      b3.ls_req  = 1'b1; b3.ls_addr  = 32'h54;
      q3.push_back('{W_DBG, 32'hA5A5A5A5});
      q3.push_back('{W_LS,  32'h5A5A5A5A});
      for (int c = 1; c <= 10; c++) begin
         step();
         eg = (c == 1) ? 32'b100 : (c == 6) ? 32'b010 : 32'b000;
         er = (c == 4) ? 32'b100 : (c == 9) ? 32'b010 : 32'b000;
         check("lat3_gnt", 32'(gnt3), eg);
         check("lat3_rvalid", 32'(rv3), er);
         if (gnt3[2]) b3.dbg_req = 1'b0;
         if (gnt3[1]) b3.ls_req  = 1'b0;
      end

      // Reset during WAIT of an ls read: no response, pending fetch served afterwards
      b3.ls_req = 1'b1; b3.ls_addr = 32'h54;
      step();
      check("rstop_ls_gnt", 32'(gnt3), 32'b010);
      b3.ls_req = 1'b0;
      step();
      rst3 = 1'b0;
      b3.if_req = 1'b1; b3.if_addr = 32'h58;
      q3.push_back('{W_IF, 32'h0BADF00D});
      step();
      check("rstop_busy", 32'(b3.busy), 0);
      check("rstop_mem_en", 32'(b3.mem_en), 0);
      check("rstop_mem_we", 32'(b3.mem_we), 0);
      check("rstop_mem_addr", b3.mem_addr, 0);
      check("rstop_mem_wdata", b3.mem_wdata, 0);
      check("rstop_mem_be", 32'(b3.mem_be), 0);
      check("rstop_gnt", 32'(gnt3), 0);
      check("rstop_rvalid", 32'(rv3), 0);
      check("rstop_rdata", b3.rdata, 0);
      rst3 = 1'b1;
      for (int c = 4; c <= 8; c++) begin
         step();
         eg = (c == 4) ? 32'b001 : 32'b000;
         er = (c == 7) ? 32'b001 : 32'b000;
         check("rstop_after_gnt", 32'(gnt3), eg);
         check("rstop_after_rvalid", 32'(rv3), er);
         if (gnt3[0]) b3.if_req = 1'b0;
      end

      check("sb1_drained", 32'(q1.size()), 0);
      check("sb3_drained", 32'(q3.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port program/data memory between three requesters: debug/loader (dbg), load/store unit (ls) and instruction fetch (if).
- Sits between the RISCV_Processor core pipeline and the memory macro.
- Allows only one outstanding transaction at a time.
- Fixed priority with a starvation guard for instruction fetch; valid/grant/response handshake per requester.

Parameters:
- ADDR_W, 32, address width for all ports.
- DATA_W, 32, data width for all ports.
- MEM_LAT, 1, cycles from the mem_en cycle to mem_rdata valid; legal range 1..15.
- STARVE_MAX, 4, consecutive lost arbitrations for if before it is promoted above ls; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-low reset
- dbg_req  in  1  debug request; hold until dbg_gnt
- dbg_we  in  1  1=write, 0=read
- dbg_addr  in  ADDR_W  debug address
- dbg_wdata  in  DATA_W  debug write data
- dbg_be  in  DATA_W/8  debug byte enables
- dbg_gnt  out  1  one-cycle grant pulse
- dbg_rvalid  out  1  one-cycle response pulse (read data or write ack)
- ls_req, ls_we, ls_addr, ls_wdata, ls_be, ls_gnt, ls_rvalid  same as dbg_* for the load/store unit
- if_req  in  1  fetch request; read only
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch grant pulse
- if_rvalid  out  1  fetch response pulse
- rdata  out  DATA_W  shared response data; valid only with an rvalid
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_be  out  DATA_W/8  memory byte enables
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE, owner=none, lat_cnt=0, starve_cnt=0.
  - All outputs 0.
  - Any in-flight transaction is abandoned; no rvalid is produced for it.
- State IDLE, arbitration:
  - Default priority order is dbg > ls > if.
  - If starve_cnt==STARVE_MAX and if_req=1, the order becomes dbg > if > ls.
  - Winner's we/addr/wdata/be (if: we=0, be=all ones, wdata=0) and owner are registered; next state=ISSUE.
  - No request pending: stay in IDLE.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) on each arbitration where if_req=1 and if loses.
  - Clears when if is granted or when if_req=0 in IDLE.
- State ISSUE, exactly 1 cycle:
  - mem_en=1; mem_we/addr/wdata/be come from the captured registers.
  - Owner's gnt=1; lat_cnt loads 1; next state=WAIT.
- State WAIT:
  - mem_en=0; lat_cnt increments each cycle.
  - When lat_cnt==MEM_LAT: owner's rvalid=1; rdata=mem_rdata for reads, 0 for writes; next state=IDLE.
- Timing:
  - With MEM_LAT=1: IDLE(arb)→ISSUE→WAIT(resp), 3 cycles per transaction; rvalid comes 1 cycle after gnt.
  - General case: rvalid is MEM_LAT cycles after gnt; back-to-back throughput is one transaction per MEM_LAT+2 cycles.
- Outputs outside their defined cycles:
  - Only the owner ever sees gnt/rvalid; gnt and rvalid are never high together.
  - mem_* outputs other than mem_en hold the captured values outside ISSUE.
  - rdata=0 when no rvalid is asserted.
- Requester protocol:
  - req and payload must be held stable until gnt.
  - Deasserting req after arbitration does not cancel; the captured request still issues and responds.
  - A requester may re-raise req in the same cycle as its rvalid; it is considered in the following IDLE cycle.
- Simultaneous requests: exactly one winner per IDLE cycle; losers keep req high and receive no gnt.
- Reset mid-WAIT: an issued write may still complete in memory; the arbiter emits no rvalid and restarts in IDLE.

Test Plan:
- Single fetch, MEM_LAT=1: if_req=1, if_addr=0x10 at cycle 0, mem returns 0x00500093 → mem_en/if_gnt at cycle 1, if_rvalid with rdata=0x00500093 at cycle 2, busy high cycles 1-2.
- Priority: dbg_req, ls_req and if_req all raised in the same cycle → grant order dbg, ls, if on cycles 1, 4, 7; mem_addr follows each captured address.
- Starvation, STARVE_MAX=4: ls_req held continuously, if_req held → if granted on its 5th arbitration ahead of ls; starve_cnt then 0; ls served next.
- Write ack: ls_we=1, ls_addr=0x40, ls_wdata=0xDEADBEEF, ls_be=4'b0011 → mem_we=1 and mem_be=0011 in ISSUE; ls_rvalid one cycle later with rdata=0.
- Latency param MEM_LAT=3: single dbg read → rvalid exactly 3 cycles after dbg_gnt; a second request waiting from cycle 0 is granted 5 cycles after the first grant.
- Reset mid-op: rst=0 during WAIT of an ls read → next cycle all outputs 0, no ls_rvalid; after rst=1, a pending if_req is granted normally.
